adaptive_mode_arbiter: RTL

ADAPTIVE_MODE_ARBITER -- requirements
Module: adaptive_mode_arbiter

---
 rtl/mode_arb_pkg.sv | 26 ++
 rtl/mode_target_calc.sv | 37 +++
 rtl/adaptive_mode_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mode_arb_pkg.sv
// Shared types and defaults for the adaptive execution-mode arbiter.
// Holds the FSM state enum, default parameter values and a width helper.
package mode_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUEST   = 2'd1,
    APPLY     = 2'd2,
    PROBATION = 2'd3
  } state_t;

  localparam int DEF_NUM_MODES    = 4;
  localparam int DEF_CONF_W       = 8;
  localparam int DEF_RUN_W        = 8;
  localparam int DEF_CONF_TH      = 40;
  localparam int DEF_RUNLEN_SHIFT = 2;
  localparam int DEF_PROB_CYCLES  = 8;
  localparam int DEF_TIMEOUT      = 16;
  localparam int DEF_RAMP         = 0;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mode_target_calc.sv
// Target-level computation: shift, clamp and confidence gate.
// In: wa_req, confidence, predicted_runlen, mode_sel. Out: target, accept.
module mode_target_calc
  import mode_arb_pkg::*;
#(
  parameter int NUM_MODES    = DEF_NUM_MODES,
  parameter int CONF_W       = DEF_CONF_W,
  parameter int RUN_W        = DEF_RUN_W,
  parameter int CONF_TH      = DEF_CONF_TH,
  parameter int RUNLEN_SHIFT = DEF_RUNLEN_SHIFT
) (
  input  logic                         wa_req,
  input  logic [CONF_W-1:0]            confidence,
  input  logic [RUN_W-1:0]             predicted_runlen,
  input  logic [$clog2(NUM_MODES)-1:0] mode_sel,
  output logic [$clog2(NUM_MODES)-1:0] target,
  output logic                         accept
);

  localparam int MODE_W = $clog2(NUM_MODES);
  localparam logic [RUN_W-1:0] TOP = RUN_W'(NUM_MODES - 1);
  localparam logic [CONF_W-1:0] TH = CONF_W'(CONF_TH);

  logic [RUN_W-1:0] shifted;

  always_comb begin
    shifted = predicted_runlen >> RUNLEN_SHIFT;
    // Clamp first so the comparison sees the level actually applied.
    if (shifted > TOP) begin
      target = TOP[MODE_W-1:0];
    end else begin
      target = shifted[MODE_W-1:0];
    end
    accept = wa_req && (confidence > TH) && (target != mode_sel);
  end

endmodule

// File: rtl/adaptive_mode_arbiter.sv
// Adaptive execution-mode arbiter: request/drain/apply/probation FSM.
// Optional MODE_ARB_STATS_EN adds switch_cnt/abort_cnt statistics outputs.
module adaptive_mode_arbiter
  import mode_arb_pkg::*;
#(
  parameter int NUM_MODES    = DEF_NUM_MODES,
  parameter int CONF_W       = DEF_CONF_W,
  parameter int RUN_W        = DEF_RUN_W,
  parameter int CONF_TH      = DEF_CONF_TH,
  parameter int RUNLEN_SHIFT = DEF_RUNLEN_SHIFT,
  parameter int PROB_CYCLES  = DEF_PROB_CYCLES,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int RAMP         = DEF_RAMP,
  parameter int RESET_MODE   = NUM_MODES - 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wa_req,
  input  logic [CONF_W-1:0]            confidence,
  input  logic [RUN_W-1:0]             predicted_runlen,
  input  logic                         alu_idle,
  output logic                         switch_req,
  output logic [$clog2(NUM_MODES)-1:0] mode_sel,
  output logic                         switch_done,
  output logic                         abort,
`ifdef MODE_ARB_STATS_EN
  output logic [15:0]                  switch_cnt,
  output logic [15:0]                  abort_cnt,
`endif
  output logic                         busy
);

  localparam int MODE_W = $clog2(NUM_MODES);
  localparam int WAIT_W = cnt_w(TIMEOUT);
  localparam int PROB_W = cnt_w(PROB_CYCLES);

  localparam logic [MODE_W-1:0] RST_M = MODE_W'(RESET_MODE);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [PROB_W-1:0] PROB_LAST = PROB_W'(PROB_CYCLES - 1);

  state_t              state;
  logic [MODE_W-1:0]   tgt_q;
  logic [MODE_W-1:0]   target;
  logic [MODE_W-1:0]   next_mode;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [PROB_W-1:0]   prob_cnt;
  logic                accept;

  mode_target_calc #(
    .NUM_MODES    (NUM_MODES),
    .CONF_W       (CONF_W),
    .RUN_W        (RUN_W),
    .CONF_TH      (CONF_TH),
    .RUNLEN_SHIFT (RUNLEN_SHIFT)
  ) u_calc (
    .wa_req           (wa_req),
    .confidence       (confidence),
    .predicted_runlen (predicted_runlen),
    .mode_sel         (mode_sel),
    .target           (target),
    .accept           (accept)
  );

  assign switch_req = (state == REQUEST);
  assign busy       = (state != IDLE);

  // Ramp mode steps one level toward the latched target per switch.
  always_comb begin
    next_mode = tgt_q;
    if (RAMP != 0) begin
      unique case (1'b1)
        (tgt_q > mode_sel): next_mode = mode_sel + 1'b1;
        (tgt_q < mode_sel): next_mode = mode_sel - 1'b1;
        default:            next_mode = mode_sel;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_sel    <= RST_M;
      tgt_q       <= RST_M;
      wait_cnt    <= '0;
      prob_cnt    <= '0;
      switch_done <= 1'b0;
      abort       <= 1'b0;
    end else begin
      switch_done <= 1'b0;
      abort       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            tgt_q    <= target;
            wait_cnt <= '0;
            state    <= REQUEST;
          end
        end
        REQUEST: begin
          // A safe point on the final wait cycle still wins.
          if (alu_idle) begin
            wait_cnt <= '0;
            state    <= APPLY;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            abort    <= 1'b1;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        APPLY: begin
          mode_sel    <= next_mode;
          prob_cnt    <= PROB_LAST;
          switch_done <= 1'b1;
          state       <= PROBATION;
        end
        PROBATION: begin
          if (prob_cnt == '0) begin
            state <= IDLE;
          end else begin
            prob_cnt <= prob_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MODE_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      switch_cnt <= '0;
      abort_cnt  <= '0;
    end else begin
      if (switch_done && (switch_cnt != 16'hFFFF)) begin
        switch_cnt <= switch_cnt + 16'd1;
      end
      if (abort && (abort_cnt != 16'hFFFF)) begin
        abort_cnt <= abort_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
